// File: rtl/nibble_multiplexer_pkg.sv
// nibble_multiplexer_pkg: shared defaults and select-width helper for the lane selector.
//   DEF_DATA_W / DEF_NUM_IN : default lane width and lane count
//   sel_width(n)            : clog2(n) with a minimum of 1
package nibble_multiplexer_pkg;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_NUM_IN = 4;
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/nibble_multiplexer_if.sv
// nibble_multiplexer_if: lane-select bus.
//   in1 (packed lanes), sel (lane index), in_valid : master -> slave
//   out (selected lane), out_valid                 : slave -> master
interface nibble_multiplexer_if
    import nibble_multiplexer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_IN = DEF_NUM_IN
)();
    localparam int SEL_W = sel_width(NUM_IN);
    logic [NUM_IN*DATA_W-1:0] in1;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic [DATA_W-1:0]        out;
    logic                     out_valid;
    modport master (output in1, sel, in_valid, input out, out_valid);
    modport slave (input in1, sel, in_valid, output out, out_valid);
endinterface

// File: rtl/nibble_multiplexer_lane_select.sv
// nibble_multiplexer_lane_select: combinational N:1 lane pick.
//   i_in1  : packed lanes, lane i = i_in1[i*DATA_W +: DATA_W]
//   i_sel  : binary lane index
//   o_lane : selected lane, zero when i_sel >= NUM_IN
module nibble_multiplexer_lane_select
    import nibble_multiplexer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_IN = DEF_NUM_IN
)(
    input  logic [NUM_IN*DATA_W-1:0]      i_in1,
    input  logic [sel_width(NUM_IN)-1:0]  i_sel,
    output logic [DATA_W-1:0]             o_lane
);
    localparam int SEL_W = sel_width(NUM_IN);
    // Equality-decoded mux: only the matching lane is ever read, so X on other
    // lanes cannot leak, and an index past the last lane leaves the zero default.
    always_comb begin
        o_lane = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (i_sel == SEL_W'(i)) o_lane = i_in1[i*DATA_W +: DATA_W];
    end
endmodule

// File: rtl/nibble_multiplexer.sv
// nibble_multiplexer: registered N:1 lane selector, 1-cycle latency, full throughput.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of nibble_multiplexer_if (in1/sel/in_valid in, out/out_valid out)
module nibble_multiplexer
    import nibble_multiplexer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_IN = DEF_NUM_IN
)(
    input logic                  clk,
    input logic                  rst,
    nibble_multiplexer_if.slave  bus
);
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] r_out;
    logic              r_valid;
    nibble_multiplexer_lane_select #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) u_sel (
        .i_in1  (bus.in1),
        .i_sel  (bus.sel),
        .o_lane (w_lane)
    );
    // out keeps its last value on idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) r_out <= w_lane;
        end
    end
    assign bus.out       = r_out;
    assign bus.out_valid = r_valid;
endmodule

// File: tb/tb_nibble_multiplexer.sv
// tb_nibble_multiplexer: directed-vector bench for default and 3x8 configurations.
module tb_nibble_multiplexer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    nibble_multiplexer_if #(.DATA_W(4), .NUM_IN(4)) a_if ();
    nibble_multiplexer_if #(.DATA_W(8), .NUM_IN(3)) b_if ();

    nibble_multiplexer #(.DATA_W(4), .NUM_IN(4)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    nibble_multiplexer #(.DATA_W(8), .NUM_IN(3)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d, input logic [1:0] s);
        a_if.in_valid = v;
        a_if.in1      = d;
        a_if.sel      = s;
        step();
    endtask

    task automatic drive_b(input logic v, input logic [23:0] d, input logic [1:0] s);
        b_if.in_valid = v;
        b_if.in1      = d;
        b_if.sel      = s;
        step();
    endtask

    task automatic check_a(input string tag, input logic [3:0] exp_out, input logic exp_v);
        check({tag, "_out"}, 32'(a_if.out), 32'(exp_out));
        check({tag, "_vld"}, 32'(a_if.out_valid), 32'(exp_v));
    endtask

    task automatic check_b(input string tag, input logic [7:0] exp_out, input logic exp_v);
        check({tag, "_out"}, 32'(b_if.out), 32'(exp_out));
        check({tag, "_vld"}, 32'(b_if.out_valid), 32'(exp_v));
    endtask

    logic [15:0] iso;

    initial begin
        rst = 1'b1;
        b_if.in_valid = 1'b1;
        b_if.in1 = 24'hFFFFFF;
        b_if.sel = 2'd1;
        step();
        drive_a(1'b1, 16'hFFFF, 2'd3);
        check_a("reset", 4'h0, 1'b0);
        check_b("reset_b", 8'h00, 1'b0);
        rst = 1'b0;
        b_if.in_valid = 1'b0;

        drive_a(1'b1, 16'hFFF0, 2'd0); check_a("sweep0", 4'h0, 1'b1);
        drive_a(1'b1, 16'hFF10, 2'd1); check_a("sweep1", 4'h1, 1'b1);
        drive_a(1'b1, 16'hF2F0, 2'd2); check_a("sweep2", 4'h2, 1'b1);
        drive_a(1'b1, 16'h3000, 2'd3); check_a("sweep3", 4'h3, 1'b1);

        drive_a(1'b1, 16'hA5C3, 2'd3); check_a("b2b_3", 4'hA, 1'b1);
        drive_a(1'b1, 16'hA5C3, 2'd0); check_a("b2b_0", 4'h3, 1'b1);
        drive_a(1'b1, 16'hA5C3, 2'd2); check_a("b2b_2", 4'h5, 1'b1);

        drive_a(1'b1, 16'hA5C3, 2'd3); check_a("pre_hold", 4'hA, 1'b1);
        drive_a(1'b0, 16'h1234, 2'd1); check_a("hold1", 4'hA, 1'b0);
        drive_a(1'b0, 16'h0000, 2'd2); check_a("hold2", 4'hA, 1'b0);

        iso = 16'bxxxx_xxxx_0110_xxxx;
        drive_a(1'b1, iso, 2'd1); check_a("isolate", 4'h6, 1'b1);

        drive_a(1'b1, 16'h0B00, 2'd2); check_a("pre_rst", 4'hB, 1'b1);
        rst = 1'b1;
        drive_a(1'b1, 16'h0B00, 2'd2); check_a("mid_rst", 4'h0, 1'b0);
        rst = 1'b0;
        drive_a(1'b1, 16'h7000, 2'd3); check_a("post_rst", 4'h7, 1'b1);
        drive_a(1'b0, 16'h0000, 2'd0);

        drive_b(1'b1, 24'h112233, 2'd2); check_b("np2_sel2", 8'h11, 1'b1);
        drive_b(1'b1, 24'h112233, 2'd3); check_b("np2_oor", 8'h00, 1'b1);
        drive_b(1'b1, 24'h112233, 2'd0); check_b("np2_sel0", 8'h33, 1'b1);
        drive_b(1'b1, 24'h112233, 2'd1); check_b("np2_sel1", 8'h22, 1'b1);
        drive_b(1'b0, 24'h000000, 2'd3); check_b("np2_idle", 8'h22, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
